ascii_dec_parser: RTL and testbench
===================================

# ascii_dec_parser

Receives a stream of ASCII characters from the UART receive path, one byte per strobe, and assembles decimal digit strings into binary values. This is the inbound counterpart of the frequency meter's digit-to-ASCII display path: host commands such as a gate-time setting arrive as text and leave this block as a ready-to-use number. Results, and malformed-input errors, are reported with single-cycle pulses.

## Interface
- `MAX_DIGITS`, default 8: maximum digits accepted per number (1–9).
- `VALUE_W`, default 32: width of the binary result. Must be at least ceil(MAX_DIGITS·log2 10); 27 suffices for 8 digits.

- `CLK` in, 1: single clock. All logic is on its rising edge.
- `RST_n` in, 1: asynchronous, active-low reset.
- `Rx_valid` in, 1: one-cycle strobe; `Rx_data` is valid in the same cycle. Back-to-back strobes are allowed.
- `Rx_data` in, 8: received ASCII byte.
- `Value_out` out, VALUE_W: last successfully parsed number. Holds until the next success.
- `Value_valid` out, 1: one-cycle pulse when `Value_out` is updated.
- `Digit_cnt` out, 4: number of digits in the last successful number.
- `Err_out` out, 1: one-cycle pulse when a malformed token is dropped.

## Operation
- Character classes:
  - DIGIT: 0x30–0x39.
  - TERM: 0x0D (CR), 0x0A (LF) or 0x20 (space).
  - OTHER: every other byte.
- Internal state: accumulator `acc` (VALUE_W bits) and counter `cnt` (4 bits).
- FSM states: IDLE, ACCUM, DISCARD. Bytes are processed only in cycles where `Rx_valid`=1.
- IDLE:
  - DIGIT: `acc`←digit, `cnt`←1, go to ACCUM.
  - TERM: ignored, stay in IDLE. This absorbs CRLF pairs and repeated spaces.
  - OTHER: go to DISCARD.
- ACCUM:
  - DIGIT with `cnt`<MAX_DIGITS: `acc`←`acc`·10 + digit (computed as (acc<<3)+(acc<<1)+d, truncated to VALUE_W), `cnt`←`cnt`+1.
  - DIGIT with `cnt`=MAX_DIGITS (overflow): go to DISCARD.
  - TERM: `Value_out`←`acc`, `Digit_cnt`←`cnt`, pulse `Value_valid`, go to IDLE.
  - OTHER: go to DISCARD.
- DISCARD:
  - DIGIT and OTHER: ignored.
  - TERM: pulse `Err_out`, go to IDLE.
- Leading zeros count toward `cnt`. For example, "007" gives value 7 and `Digit_cnt`=3.
- Reset mid-token: the partial token is lost. No pulse is issued after reset is released.

## Timing
- Reset values: `Value_out`=0, `Value_valid`=0, `Digit_cnt`=0, `Err_out`=0. FSM in IDLE, `acc`=0, `cnt`=0.
- Latency: `Value_valid` / `Err_out` assert on the edge after the cycle in which the terminating byte's `Rx_valid` is high. `Value_out` and `Digit_cnt` change on that same edge.
- `Value_valid` and `Err_out` are mutually exclusive and never high for two consecutive cycles from a single terminator.
- Back-to-back bytes, e.g. "5" then CR on consecutive cycles, require no idle gap. A digit arriving in the same cycle as a `Value_valid` pulse starts the next token normally.
- `Rx_data` is ignored whenever `Rx_valid`=0.

## Configuration
- `ASCII_DEC_PARSER_BCD_EN` defined:
  - Adds output `Bcd_out` of width 4·MAX_DIGITS, holding the packed BCD of the last successful token. Least significant digit is in bits [3:0].
  - Unused upper nibbles are 0.
  - `Bcd_out` resets to 0 and updates on the same edge as `Value_out`.
  - It is built from a parallel BCD shift register: shift left 4 bits per digit.
- `ASCII_DEC_PARSER_BCD_EN` not defined: port and register are absent. All other behaviour is identical.

## Test plan
- Reset, then bytes "1","2","3",CR on consecutive cycles. Required: one `Value_valid` pulse one cycle after CR, `Value_out`=123, `Digit_cnt`=3, and with BCD enabled `Bcd_out`=0x00000123.
- "4","2",CR,LF. Required: one result of 42 and no pulse for the LF.
- "1","x","5",CR. Required: `Err_out` pulses once, `Value_out` keeps its prior value, no `Value_valid`.
- Nine digits "123456789" then CR with MAX_DIGITS=8. Required: `Err_out` pulse. Then "99999999",CR gives `Value_out`=99999999 and `Digit_cnt`=8.
- "7","8" then `RST_n` low for one cycle, then "5",space. Required: all outputs 0 during reset, then `Value_out`=5, `Digit_cnt`=1.
- "3" with gaps of 0–5 idle cycles between strobes, and garbage on `Rx_data` while `Rx_valid`=0, then "0",CR. Required: `Value_out`=30.

Source files
------------

// File: rtl/ascii_dec_parser.sv
// ============================================================================
// Module   : ascii_dec_parser
// Purpose  : Assembles ASCII decimal digit strings into binary values; reports
//            results and malformed tokens with single-cycle pulses.
//            Optional packed-BCD copy of the result: ASCII_DEC_PARSER_BCD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_dec_parser #(
    parameter int MAX_DIGITS = 8,
    parameter int VALUE_W    = 32
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Rx_valid,
    input  logic [7:0]         Rx_data,
    output logic [VALUE_W-1:0] Value_out,
    output logic               Value_valid,
    output logic [3:0]         Digit_cnt,
    output logic               Err_out
`ifdef ASCII_DEC_PARSER_BCD_EN
    ,
    output logic [4*MAX_DIGITS-1:0] Bcd_out
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [VALUE_W-1:0] acc;
    logic [VALUE_W-1:0] acc_next;
    logic [VALUE_W-1:0] acc_scaled;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic               is_digit;
    logic               is_term;
    logic [3:0]         digit;
    logic               start_tok;
    logic               shift_tok;
    logic               load_result;
    logic               drop_token;

    assign is_digit   = (Rx_data >= 8'h30) && (Rx_data <= 8'h39);
    assign is_term    = (Rx_data == 8'h0D) || (Rx_data == 8'h0A) || (Rx_data == 8'h20);
    assign digit      = Rx_data[3:0];
    assign acc_scaled = (acc << 3) + (acc << 1) + VALUE_W'(digit);

    always_comb begin
        state_next  = state;
        start_tok   = 1'b0;
        shift_tok   = 1'b0;
        load_result = 1'b0;
        drop_token  = 1'b0;
        if (Rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        start_tok  = 1'b1;
                        state_next = ACCUM;
                    end else if (!is_term) begin
                        state_next = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        // A digit beyond the limit poisons the whole token
                        if (cnt < MAX_CNT) begin
                            shift_tok = 1'b1;
                        end else begin
                            state_next = DISCARD;
                        end
                    end else if (is_term) begin
                        load_result = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        drop_token = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (start_tok) begin
            acc_next = VALUE_W'(digit);
            cnt_next = 4'd1;
        end else if (shift_tok) begin
            acc_next = acc_scaled;
            cnt_next = cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            Value_out   <= '0;
            Value_valid <= 1'b0;
            Digit_cnt   <= '0;
            Err_out     <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
            Value_valid <= load_result;
            Err_out     <= drop_token;
            if (load_result) begin
                Value_out <= acc;
                Digit_cnt <= cnt;
            end
        end
    end

`ifdef ASCII_DEC_PARSER_BCD_EN
    localparam int BCD_W = 4 * MAX_DIGITS;

    logic [BCD_W-1:0] bcd_acc;
    logic [BCD_W-1:0] bcd_next;

    // Shifting from zero leaves unused upper nibbles clear
    always_comb begin
        bcd_next = bcd_acc;
        if (start_tok) begin
            bcd_next = BCD_W'(digit);
        end else if (shift_tok) begin
            bcd_next = (bcd_acc << 4) | BCD_W'(digit);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bcd_acc <= '0;
            Bcd_out <= '0;
        end else begin
            bcd_acc <= bcd_next;
            if (load_result) begin
                Bcd_out <= bcd_acc;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ascii_dec_parser.sv
// ============================================================================
// Module   : tb_ascii_dec_parser
// Purpose  : Directed scoreboard bench for ascii_dec_parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascii_dec_parser;

    logic        CLK;
    logic        RST_n;
    logic        Rx_valid;
    logic [7:0]  Rx_data;
    logic [31:0] Value_out;
    logic        Value_valid;
    logic [3:0]  Digit_cnt;
    logic        Err_out;
`ifdef ASCII_DEC_PARSER_BCD_EN
    logic [31:0] Bcd_out;
`endif

    ascii_dec_parser #(.MAX_DIGITS(8), .VALUE_W(32)) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Rx_valid    (Rx_valid),
        .Rx_data     (Rx_data),
        .Value_out   (Value_out),
        .Value_valid (Value_valid),
        .Digit_cnt   (Digit_cnt),
        .Err_out     (Err_out)
`ifdef ASCII_DEC_PARSER_BCD_EN
        ,
        .Bcd_out     (Bcd_out)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_err;
        logic [31:0] value;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_val = 0;
    logic [3:0]  last_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r = 0;
        logic [31:0] t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic exp_val(input logic [31:0] v, input logic [3:0] c);
        exp_t e;
        e.is_err = 1'b0; e.value = v; e.cnt = c;
        sb.push_back(e);
        last_val = v;
        last_cnt = c;
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1; e.value = last_val; e.cnt = last_cnt;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_valid = 1'b1;
        Rx_data  = b;
        @(posedge CLK); #1;
        Rx_valid = 1'b0;
        Rx_data  = 8'($urandom);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            Rx_data = 8'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    // Scoreboard side: every pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (RST_n && (Value_valid || Err_out)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'({Value_valid, Err_out}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", 64'({Value_valid, Err_out}), e.is_err ? 64'd1 : 64'd2);
                check("value_out", 64'(Value_out), 64'(e.value));
                check("digit_cnt", 64'(Digit_cnt), 64'(e.cnt));
`ifdef ASCII_DEC_PARSER_BCD_EN
                check("bcd_out", 64'(Bcd_out), 64'(to_bcd(e.value)));
`endif
            end
        end
    end

    initial begin
        RST_n    = 1'b0;
        Rx_valid = 1'b0;
        Rx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_value_out", 64'(Value_out), 64'd0);
        check("rst_value_valid", 64'(Value_valid), 64'd0);
        check("rst_digit_cnt", 64'(Digit_cnt), 64'd0);
        check("rst_err_out", 64'(Err_out), 64'd0);
`ifdef ASCII_DEC_PARSER_BCD_EN
        check("rst_bcd_out", 64'(Bcd_out), 64'd0);
`endif
        RST_n = 1'b1;
        idle(2);

        exp_val(123, 3);       send_str("123\r");
        idle(1);
        check("pulse_is_single", 64'(Value_valid), 64'd0);
        exp_val(42, 2);        send_str("42\r\n");
        exp_err();             send_str("1x5\r");
        exp_err();             send_str("123456789\r");
        exp_val(99999999, 8);  send_str("99999999\r");
        exp_val(7, 3);         send_str("  007 ");
        exp_val(12, 2);        send_str("12 ");
        exp_val(3, 1);         send_str("3\n");
        idle(3);

        // Reset in the middle of a token drops it and clears all outputs
        send_str("78");
        RST_n = 1'b0;
        #2;
        check("midrst_value_out", 64'(Value_out), 64'd0);
        check("midrst_digit_cnt", 64'(Digit_cnt), 64'd0);
        check("midrst_pulses", 64'({Value_valid, Err_out}), 64'd0);
        @(posedge CLK); #1;
        RST_n = 1'b1;
        last_val = 0;
        last_cnt = 0;
        idle(1);
        exp_val(5, 1);         send_str("5 ");

        // Idle gaps with garbage on the data bus while not valid
        exp_val(30, 2);
        for (int g = 0; g <= 5; g++) begin
            idle(g);
            send_str(" ");
        end
        send_str("3");
        idle(5);
        send_str("0");
        idle(2);
        send_str("\r");

        idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
